// File: rtl/data_mem_responder_if.sv
// ---------------------------------------------------------------------------
// data_mem_responder_if
// Request/response bundle between the CPU data-memory port and the
// data_mem_responder.
//   req_valid/req_ready     request handshake (master drives valid)
//   req_write               1 = store, 0 = load
//   req_addr[31:0]          byte address
//   req_wdata[31:0]         store data (byte in [7:0], half in [15:0])
//   req_size[1:0]           00 byte, 01 half, 10 word, 11 reserved
//   req_unsigned            loads: 1 = zero-extend, 0 = sign-extend
//   resp_valid/resp_ready   response handshake (slave drives valid)
//   resp_rdata[31:0]        extended load data, 0 for stores and errors
//   resp_error              request rejected (only with DMEM_ERR_EN)
// ---------------------------------------------------------------------------
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned,
    output resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned,
    input  resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
// Memory-side responder for the CPU data-memory port. Accepts one load/store
// at a time, waits WAIT_STATES cycles, performs a byte/half/word access to an
// internal word-organised RAM and returns the (extended) load data over a
// valid/ready response channel.
//
// Ports
//   clock   in  system clock, all state on posedge
//   reset   in  asynchronous active-low reset (RAM contents are not reset)
//   bus     slave modport of data_mem_responder_if (request + response)
//
// Parameters
//   DEPTH_WORDS  RAM size in 32-bit words (power of two when DMEM_ERR_EN is
//                undefined, so the word index wraps by truncation)
//   WAIT_STATES  extra cycles between accept and RAM access (0..15)
//
// Build option
//   DMEM_ERR_EN  defined: misaligned half/word, out-of-range address and
//                reserved size return resp_error=1, resp_rdata=0, no RAM
//                access. Undefined: resp_error is always 0, misaligned low
//                address bits are forced to alignment, size 11 acts as word
//                and the word index wraps modulo DEPTH_WORDS.
// ---------------------------------------------------------------------------
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  data_mem_responder_if.slave   bus
);

  localparam int         AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        accept;

  logic        write_p0;
  logic [31:0] addr_p0;
  logic [31:0] wdata_p0;
  logic [1:0]  size_p0;
  logic        uns_p0;

  logic [1:0]    size_eff;
  logic [1:0]    lane;
  logic          err;
  logic [AW-1:0] idx;
  logic [3:0]    wmask;
  logic [31:0]   wlanes;
  logic [31:0]   rd_word;
  logic [31:0]   shifted;
  logic [31:0]   load_data;
  logic          do_write;

  logic [31:0] resp_rdata_q;
  logic        resp_error_q;

  logic [31:0] mem [DEPTH_WORDS];

  // Right-aligned byte/half/word to 32 bits, sign- or zero-extended.
  function automatic logic [31:0] extend_load(input logic [31:0] val,
                                              input logic [1:0]  size,
                                              input logic        uns);
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    b_s = val[7:0];
    h_s = val[15:0];
    case (size)
      2'b00:   return uns ? {24'd0, val[7:0]}  : 32'(b_s);
      2'b01:   return uns ? {16'd0, val[15:0]} : 32'(h_s);
      default: return val;
    endcase
  endfunction

  assign accept = bus.req_valid && (state_q == S_IDLE);

  // Request capture: later changes on req_* are ignored until back in IDLE.
  always_ff @(posedge clock) begin
    if (accept) begin
      write_p0 <= bus.req_write;
      addr_p0  <= bus.req_addr;
      wdata_p0 <= bus.req_wdata;
      size_p0  <= bus.req_size;
      uns_p0   <= bus.req_unsigned;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (WAIT_STATES > 0) begin
            state_d    = S_WAIT;
            wait_cnt_d = WS;
          end else begin
            state_d    = S_ACCESS;
          end
        end
      end
      S_WAIT: begin
        // Leaving on a count of 1 gives exactly WAIT_STATES cycles here.
        if (wait_cnt_q <= 4'd1) begin
          state_d    = S_ACCESS;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      S_ACCESS: state_d = S_RESP;
      S_RESP: begin
        if (bus.resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Access decode from the captured request.
  always_comb begin
    size_eff = size_p0;
    err      = 1'b0;
`ifdef DMEM_ERR_EN
    err = (size_p0 == 2'b11) ||
          ((size_p0 == 2'b01) && addr_p0[0]) ||
          ((size_p0 == 2'b10) && (addr_p0[1:0] != 2'b00)) ||
          (addr_p0[31:2] >= 30'(DEPTH_WORDS));
`else
    if (size_p0 == 2'b11) size_eff = 2'b10;
`endif
    case (size_eff)
      2'b00:   lane = addr_p0[1:0];
      2'b01:   lane = {addr_p0[1], 1'b0};
      default: lane = 2'b00;
    endcase
    case (size_eff)
      2'b00: begin
        wmask  = 4'b0001 << lane;
        wlanes = {4{wdata_p0[7:0]}};
      end
      2'b01: begin
        wmask  = 4'b0011 << lane;
        wlanes = {2{wdata_p0[15:0]}};
      end
      default: begin
        wmask  = 4'b1111;
        wlanes = wdata_p0;
      end
    endcase
    idx       = addr_p0[AW+1:2];
    rd_word   = mem[idx];
    shifted   = rd_word >> {lane, 3'b000};
    load_data = extend_load(shifted, size_eff, uns_p0);
  end

`ifndef DMEM_ERR_EN
  // Address bits above the RAM are dropped: the index wraps.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_p0[31:AW+2];
`endif

  assign do_write = (state_q == S_ACCESS) && write_p0 && !err;

  // RAM: byte-lane write only in ACCESS, contents survive reset.
  always_ff @(posedge clock) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) mem[idx][8*b +: 8] <= wlanes[8*b +: 8];
      end
    end
  end

  // Response registers, loaded in ACCESS and held through RESP.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      resp_rdata_q <= '0;
      resp_error_q <= 1'b0;
    end else if (state_q == S_ACCESS) begin
      resp_rdata_q <= (write_p0 || err) ? 32'd0 : load_data;
      resp_error_q <= err;
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.resp_rdata = resp_rdata_q;
`ifdef DMEM_ERR_EN
  assign bus.resp_error = resp_error_q;
`else
  assign bus.resp_error = 1'b0;
  logic unused_err_q;
  assign unused_err_q = resp_error_q;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
  localparam int DEPTH = 256;
  localparam int WS    = 1;

  logic clock = 1'b0;
  logic reset = 1'b0;

  data_mem_responder_if bus();

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] exp_rdata;
    logic        exp_err;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  vec_t common_q[$];
  vec_t cfg_q[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [1:0] s, input logic u, input logic [31:0] er,
                              input logic ee, input string n);
    vec_t v;
    v.write = w; v.addr = a; v.wdata = d; v.size = s; v.uns = u;
    v.exp_rdata = er; v.exp_err = ee; v.name = n;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic send(input vec_t v, input bit expect_resp);
    int n = 0;
    @(negedge clock);
    bus.req_valid    = 1'b1;
    bus.req_write    = v.write;
    bus.req_addr     = v.addr;
    bus.req_wdata    = v.wdata;
    bus.req_size     = v.size;
    bus.req_unsigned = v.uns;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk({v.name, " accept_ready"}, 32'(bus.req_ready), 32'd1);
    @(posedge clock);
    #1;
    // Scramble the request lines: the captured copy must be used.
    bus.req_valid    = 1'b0;
    bus.req_write    = ~v.write;
    bus.req_addr     = $urandom;
    bus.req_wdata    = $urandom;
    bus.req_size     = 2'($urandom);
    bus.req_unsigned = ~v.uns;
    if (expect_resp) sb.push_back('{v.exp_rdata, v.exp_err, v.name});
  endtask

  // Waits for resp_valid (bounded), checks latency, pops and compares.
  task automatic wait_and_check();
    int   k = 0;
    exp_t e;
    do begin
      @(negedge clock);
      k++;
    end while (bus.resp_valid !== 1'b1 && k < 30);
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_empty: got=response want=none");
    end else begin
      e = sb.pop_front();
      chk({e.name, " latency"}, 32'(k - 1), 32'(WS + 1));
      chk({e.name, " rdata"}, bus.resp_rdata, e.rdata);
      chk({e.name, " error"}, 32'(bus.resp_error), 32'(e.err));
    end
  endtask

  task automatic run_vec(input vec_t v);
    send(v, 1'b1);
    wait_and_check();
    @(negedge clock);
    chk({v.name, " resp_done"}, 32'(bus.resp_valid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    common_q.push_back(mk(1, 32'h10, 32'hDEADBEEF, 2'b10, 0, 32'h0,        0, "sw_10"));
    common_q.push_back(mk(0, 32'h10, 32'h0,        2'b10, 0, 32'hDEADBEEF, 0, "lw_10"));
    common_q.push_back(mk(0, 32'h13, 32'h0,        2'b00, 0, 32'hFFFFFFDE, 0, "lb_13"));
    common_q.push_back(mk(0, 32'h13, 32'h0,        2'b00, 1, 32'h000000DE, 0, "lbu_13"));
    common_q.push_back(mk(0, 32'h10, 32'h0,        2'b01, 0, 32'hFFFFBEEF, 0, "lh_10"));
    common_q.push_back(mk(0, 32'h12, 32'h0,        2'b01, 1, 32'h0000DEAD, 0, "lhu_12"));
    common_q.push_back(mk(1, 32'h11, 32'hAAAAAA55, 2'b00, 0, 32'h0,        0, "sb_11"));
    common_q.push_back(mk(0, 32'h10, 32'h0,        2'b10, 0, 32'hDEAD55EF, 0, "lw_10_after_sb"));
    common_q.push_back(mk(1, 32'h20, 32'h0,        2'b10, 0, 32'h0,        0, "sw_20"));
    common_q.push_back(mk(1, 32'h22, 32'h5A5A8001, 2'b01, 0, 32'h0,        0, "sh_22"));
    common_q.push_back(mk(0, 32'h20, 32'h0,        2'b10, 0, 32'h80010000, 0, "lw_20"));
    common_q.push_back(mk(0, 32'h22, 32'h0,        2'b01, 0, 32'hFFFF8001, 0, "lh_22"));
    common_q.push_back(mk(0, 32'h23, 32'h0,        2'b00, 1, 32'h00000080, 0, "lbu_23"));
    common_q.push_back(mk(0, 32'h21, 32'h0,        2'b00, 0, 32'h00000000, 0, "lb_21"));
`ifdef DMEM_ERR_EN
    cfg_q.push_back(mk(0, 32'h12,  32'h0,        2'b10, 0, 32'h0,        1, "lw_mis_12"));
    cfg_q.push_back(mk(0, 32'h11,  32'h0,        2'b01, 0, 32'h0,        1, "lh_mis_11"));
    cfg_q.push_back(mk(0, 32'h10,  32'h0,        2'b11, 0, 32'h0,        1, "size_rsvd"));
    cfg_q.push_back(mk(1, 32'h400, 32'h12345678, 2'b10, 0, 32'h0,        1, "sw_oor_400"));
    cfg_q.push_back(mk(1, 32'h410, 32'h12345678, 2'b10, 0, 32'h0,        1, "sw_oor_410"));
    cfg_q.push_back(mk(0, 32'h10,  32'h0,        2'b10, 0, 32'hDEAD55EF, 0, "lw_10_unchanged"));
    cfg_q.push_back(mk(1, 32'h3FC, 32'hA5A5A5A5, 2'b10, 0, 32'h0,        0, "sw_top"));
    cfg_q.push_back(mk(0, 32'h3FC, 32'h0,        2'b10, 0, 32'hA5A5A5A5, 0, "lw_top"));
`else
    cfg_q.push_back(mk(0, 32'h412, 32'h0,        2'b10, 0, 32'hDEAD55EF, 0, "lw_wrap_mis"));
    cfg_q.push_back(mk(1, 32'h411, 32'hCAFEF00D, 2'b11, 0, 32'h0,        0, "sw_rsvd_wrap"));
    cfg_q.push_back(mk(0, 32'h10,  32'h0,        2'b10, 0, 32'hCAFEF00D, 0, "lw_10_after"));
    cfg_q.push_back(mk(0, 32'h13,  32'h0,        2'b01, 0, 32'hFFFFCAFE, 0, "lh_mis_13"));
    cfg_q.push_back(mk(1, 32'h3FC, 32'hA5A5A5A5, 2'b10, 0, 32'h0,        0, "sw_top"));
    cfg_q.push_back(mk(0, 32'h7FD, 32'h0,        2'b00, 1, 32'h000000A5, 0, "lbu_wrap_7fd"));
`endif

    // Reset held with a store pending.
    bus.resp_ready   = 1'b1;
    bus.req_valid    = 1'b1;
    bus.req_write    = 1'b1;
    bus.req_addr     = 32'h10;
    bus.req_wdata    = 32'hBAD0BAD0;
    bus.req_size     = 2'b10;
    bus.req_unsigned = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst req_ready",  32'(bus.req_ready),  32'd1);
    chk("rst resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst resp_rdata", bus.resp_rdata,      32'd0);
    chk("rst resp_error", 32'(bus.resp_error), 32'd0);
    bus.req_valid = 1'b0;
    reset = 1'b1;

    foreach (common_q[i]) run_vec(common_q[i]);

    // Back-pressure: response held for 5 cycles, no new request taken.
    bus.resp_ready = 1'b0;
    send(mk(0, 32'h10, 32'h0, 2'b10, 0, 32'hDEAD55EF, 0, "bp_lw"), 1'b1);
    wait_and_check();
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 32'h10;
    bus.req_wdata = 32'h0;
    bus.req_size  = 2'b10;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      chk("bp resp_valid", 32'(bus.resp_valid), 32'd1);
      chk("bp resp_rdata", bus.resp_rdata,      32'hDEAD55EF);
      chk("bp req_ready",  32'(bus.req_ready),  32'd0);
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(negedge clock);
    chk("bp released", 32'(bus.resp_valid), 32'd0);
    chk("bp idle",     32'(bus.req_ready),  32'd1);

    // Reset in the middle of a store: dropped, no write, no response.
    @(negedge clock);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 32'h10;
    bus.req_wdata = 32'h77777777;
    bus.req_size  = 2'b10;
    @(posedge clock);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("midrst resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("midrst req_ready",  32'(bus.req_ready),  32'd1);
    chk("midrst resp_rdata", bus.resp_rdata,      32'd0);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("midrst no_resp", 32'(bus.resp_valid), 32'd0);
    run_vec(mk(0, 32'h10, 32'h0, 2'b10, 0, 32'hDEAD55EF, 0, "midrst_lw_10"));

    foreach (cfg_q[i]) run_vec(cfg_q[i]);

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_left: got=%0d want=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
